spi_slave_fsm: RTL and testbench

- Serial front end of the SPI slave interface. Deserialises MOSI frames into 10-bit command/data words for the synchronous RAM (rx_data/rx_valid).
- Serialises the RAM's read data (tx_data/tx_valid) back out on MISO.
- Sits directly upstream of the RAM and consumes its dout/tx_valid; clk is the SPI serial clock.

---
 rtl/spi_slave_fsm_if.sv | 13 +
 rtl/spi_slave_fsm.sv | 105 ++++++++++
 tb/tb_spi_slave_fsm.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_fsm_if.sv
// SPI slave serial pins plus the word-level handshake toward the RAM.
interface spi_slave_fsm_if #(parameter int DATA_W = 8);
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave  (input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid);
    modport master (output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: MOSI frames to RAM command words, RAM read data back out on MISO.
module spi_slave_fsm #(
    parameter int DATA_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    spi_slave_fsm_if.slave bus
);
    localparam int RXW = DATA_W + 2;
    localparam int CW  = $clog2(RXW + 1);
    localparam int TCW = $clog2(DATA_W + 2);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RXW-2:0]    rx_shift_q, rx_shift_d;
    logic [RXW-1:0]    rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rd_addr_seen_q, rd_addr_seen_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [TCW-1:0]    tx_cnt_q, tx_cnt_d;
    logic              miso_q, miso_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            tx_shift_q     <= tx_shift_d;
            tx_cnt_q       <= tx_cnt_d;
            miso_q         <= miso_d;
        end
    end

    // tx_cnt_q: 0 = waiting for tx_valid, 1..DATA_W = bit on MISO, DATA_W+1 = transfer finished
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        tx_shift_d     = tx_shift_q;
        tx_cnt_d       = tx_cnt_q;
        miso_d         = 1'b0;

        if (state_q == IDLE || bus.SS_n) begin
            cnt_d      = '0;
            rx_shift_d = '0;
            tx_shift_d = '0;
            tx_cnt_d   = '0;
            if (state_q != IDLE)
                state_d = IDLE;
            else if (!bus.SS_n)
                state_d = CHK_CMD;
        end else if (state_q == CHK_CMD) begin
            if (!bus.MOSI)
                state_d = WRITE;
            else
                state_d = rd_addr_seen_q ? READ_DATA : READ_ADD;
        end else if (cnt_q < CW'(RXW)) begin
            rx_shift_d = {rx_shift_q[RXW-3:0], bus.MOSI};
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CW'(RXW - 1)) begin
                rx_data_d  = {rx_shift_q, bus.MOSI};
                rx_valid_d = 1'b1;
                if (state_q == READ_ADD)
                    rd_addr_seen_d = 1'b1;
            end
        end else if (state_q == READ_DATA) begin
            if (tx_cnt_q == '0) begin
                if (bus.tx_valid) begin
                    miso_d     = bus.tx_data[DATA_W-1];
                    tx_shift_d = {bus.tx_data[DATA_W-2:0], 1'b0};
                    tx_cnt_d   = TCW'(1);
                end
            end else if (tx_cnt_q < TCW'(DATA_W)) begin
                miso_d     = tx_shift_q[DATA_W-1];
                tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                tx_cnt_d   = tx_cnt_q + 1'b1;
            end else if (tx_cnt_q == TCW'(DATA_W)) begin
                tx_cnt_d       = TCW'(DATA_W + 1);
                rd_addr_seen_d = 1'b0;
            end
        end
    end

    assign bus.MISO     = miso_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_slave_fsm.sv
// Scoreboard bench: expected rx words (with due cycle) and MISO bits are queued as stimulus is driven.
module tb_spi_slave_fsm;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_slave_fsm_if #(.DATA_W(8)) bus ();
    spi_slave_fsm #(.DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [9:0] word;
        int         due;
    } rx_exp_t;

    rx_exp_t    rq[$];
    logic       mq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         mon_en = 0;
    logic [9:0] last_rx = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge
    initial begin
        rx_exp_t e;
        logic    em;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                em = 1'b0;
                if (mq.size() > 0) em = mq.pop_front();
                chk("miso", bus.MISO, em);
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    e = rq.pop_front();
                    chk("rx_valid", bus.rx_valid, 1);
                    chk("rx_data", bus.rx_data, e.word);
                    last_rx = e.word;
                end else begin
                    chk("rx_valid_idle", bus.rx_valid, 0);
                    chk("rx_hold", bus.rx_data, last_rx);
                end
            end
        end
    end

    task automatic drv(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
        @(negedge clk);
        bus.SS_n     = ss;
        bus.MOSI     = mosi;
        bus.tx_valid = txv;
        bus.tx_data  = txd;
    endtask

    task automatic send_frame(input logic mode, input logic [9:0] w, input int nbits);
        rx_exp_t e;
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        drv(1'b0, mode, 1'b0, 8'h00);
        for (int i = 0; i < nbits; i++) begin
            drv(1'b0, w[9-i], 1'b0, 8'h00);
            if (i == 9) begin
                e.word = w;
                e.due  = cyc + 1;
                rq.push_back(e);
            end
        end
    endtask

    task automatic end_frame();
        drv(1'b1, 1'b0, 1'b0, 8'h00);
        drv(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic tx_pulse(input logic [7:0] d, input bit shifted);
        drv(1'b0, 1'b0, 1'b1, d);
        if (shifted)
            for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_miso", bus.MISO, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        mon_en = 1;
        @(negedge clk);
        rst_n = 1'b1;

        // spurious tx_valid in IDLE
        drv(1'b1, 1'b0, 1'b1, 8'hFF);
        drv(1'b1, 1'b0, 1'b0, 8'h00);

        // write address, spurious tx_valid in WRITE, trailing bits ignored
        send_frame(1'b0, 10'h0B5, 10);
        tx_pulse(8'hAA, 0);
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        drv(1'b0, 1'b1, 1'b0, 8'h00);
        end_frame();

        // write data
        send_frame(1'b0, 10'h1E6, 10);
        end_frame();

        // read address: no MISO response
        send_frame(1'b1, 10'h2B5, 10);
        tx_pulse(8'h55, 0);
        idle(3);
        end_frame();

        // read data: 230 shifted out, later pulse ignored
        send_frame(1'b1, 10'h3C3, 10);
        tx_pulse(8'd230, 1);
        idle(9);
        tx_pulse(8'h0F, 0);
        idle(2);
        end_frame();

        // rd_addr_seen cleared: mode 1 is READ_ADD again, then READ_DATA
        send_frame(1'b1, 10'h211, 10);
        tx_pulse(8'h99, 0);
        end_frame();
        send_frame(1'b1, 10'h300, 10);
        tx_pulse(8'h5A, 1);
        idle(9);
        end_frame();

        // abort after 5 payload bits, then clean frame
        send_frame(1'b0, 10'h3FF, 5);
        end_frame();
        send_frame(1'b0, 10'h0FA, 10);
        end_frame();

        // SS_n rises with the 10th bit: no strobe
        send_frame(1'b0, 10'h155, 9);
        drv(1'b1, 1'b1, 1'b0, 8'h00);
        drv(1'b1, 1'b0, 1'b0, 8'h00);
        send_frame(1'b0, 10'h0AA, 10);
        end_frame();

        // reset after 3 MISO bits
        send_frame(1'b1, 10'h2F0, 10);
        end_frame();
        send_frame(1'b1, 10'h3F0, 10);
        tx_pulse(8'hB4, 1);
        idle(2);
        @(negedge clk);
        rst_n = 1'b0; bus.SS_n = 1'b1; bus.tx_valid = 1'b0;
        mq.delete(); rq.delete(); last_rx = '0;
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(1'b1, 10'h2B5, 10);
        tx_pulse(8'h77, 0);
        idle(2);
        end_frame();

        // SS_n abort mid-shift keeps rd_addr_seen: next mode 1 is READ_DATA
        send_frame(1'b1, 10'h301, 10);
        tx_pulse(8'hF0, 1);
        idle(2);
        drv(1'b1, 1'b0, 1'b0, 8'h00);
        mq.delete();
        drv(1'b1, 1'b0, 1'b0, 8'h00);
        send_frame(1'b1, 10'h302, 10);
        tx_pulse(8'h3C, 1);
        idle(9);
        end_frame();

        idle(2);
        end_frame();
        chk("rx_queue_empty", rq.size(), 0);
        chk("miso_queue_empty", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
